// File: rtl/ysyx_24100005_ifu_pkg.sv
// Shared types and defaults for the ysyx_24100005 instruction fetch unit.
package ysyx_24100005_ifu_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  localparam addr_t RESET_PC_DEF   = 32'h8000_0000;
  // addi x0,x0,0 : harmless filler handed to the core on a fetch fault
  localparam inst_t FAULT_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_RESP     = 2'd1,
    S_DELIVER  = 2'd2,
    S_WAIT_NPC = 2'd3
  } ifu_state_e;

  // Instruction addresses must be word aligned
  function automatic logic misaligned(input addr_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100005_ifu_if.sv
// Fetch-unit bus bundle: imem request/response, instruction delivery and
// next-PC return. master = IFU side, slave = memory/core side.
interface ysyx_24100005_ifu_if;
  import ysyx_24100005_ifu_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  addr_t imem_req_addr;
  logic  imem_resp_valid;
  inst_t imem_resp_data;
  logic  imem_resp_err;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst;
  addr_t inst_pc;
  logic  inst_fault;
  logic  npc_valid;
  addr_t npc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, npc_valid, npc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           inst_ready, npc_valid, npc
  );
endinterface

// File: rtl/ysyx_24100005_ifu_perf.sv
// Saturating fetch / stall event counters for the fetch unit.
module ysyx_24100005_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [63:0] fetch_cnt,
  output logic [63:0] stall_cnt
);

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 64'd1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one fetch in flight, PC supplied back by the core.
// Optional perf counters enabled by defining YSYX_24100005_IFU_PERF_EN.
module ysyx_24100005_ifu
  import ysyx_24100005_ifu_pkg::*;
#(
  parameter addr_t RESET_PC   = RESET_PC_DEF,
  parameter inst_t FAULT_INST = FAULT_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24100005_ifu_if.master   bus
`ifdef YSYX_24100005_IFU_PERF_EN
  ,
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_stall_cnt
`endif
);

  ifu_state_e state_q;
  addr_t      pc_q;
  inst_t      inst_q;
  addr_t      inst_pc_q;
  logic       fault_q;

  logic inst_hs;
  logic npc_take;

  assign inst_hs  = (state_q == S_DELIVER) && bus.inst_ready;
  // npc only counts together with the delivery handshake or while waiting for it
  assign npc_take = bus.npc_valid && (inst_hs || (state_q == S_WAIT_NPC));

  // Fetch FSM, PC register and delivered-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_REQ:     if (bus.imem_req_ready) state_q <= S_RESP;
        S_RESP:    if (bus.imem_resp_valid) begin
                     inst_q    <= bus.imem_resp_err ? FAULT_INST : bus.imem_resp_data;
                     fault_q   <= bus.imem_resp_err;
                     inst_pc_q <= pc_q;
                     state_q   <= S_DELIVER;
                   end
        S_DELIVER: if (bus.inst_ready) state_q <= S_WAIT_NPC;
        default:   ;
      endcase
      // Accepted next PC overrides the above: fetch it, or fault it
      // straight into DELIVER without touching memory if misaligned.
      if (npc_take) begin
        pc_q <= bus.npc;
        if (misaligned(bus.npc)) begin
          inst_q    <= FAULT_INST;
          fault_q   <= 1'b1;
          inst_pc_q <= bus.npc;
          state_q   <= S_DELIVER;
        end else begin
          state_q   <= S_REQ;
        end
      end
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_DELIVER);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_fault     = fault_q;

`ifdef YSYX_24100005_IFU_PERF_EN
  logic stall_inc;
  assign stall_inc = ((state_q == S_REQ)  && !bus.imem_req_ready) ||
                     ((state_q == S_RESP) && !bus.imem_resp_valid);

  ysyx_24100005_ifu_perf u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (inst_hs),
    .stall_inc (stall_inc),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

  // Stray npc / response pulses are ignored by the FSM but flagged here
  a_npc_ignored: assert property (@(posedge clk) disable iff (rst)
    !(bus.npc_valid && !npc_take));
  a_resp_ignored: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_resp_valid && (state_q != S_RESP)));

endmodule
